// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: clips the rasterizer pixel stream to the framebuffer,
// converts RGB888 to RGB565, buffers pixels in a small FIFO and writes them
// to framebuffer memory over a req/ack handshake. Flags pixels lost to a
// full FIFO and signals draw completion once every accepted pixel is written.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no request outstanding; pops the FIFO head when non-empty
// ST_REQ   | mem_req high, address/data held until mem_ack
module fb_pixel_writer #(
    parameter int FB_W       = 160,
    parameter int FB_H       = 120,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_px,
    input  logic [7:0]        in_py,
    input  logic [23:0]       in_color,
    input  logic              in_valid,
    input  logic              in_done,
    input  logic              clear_err,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              draw_done,
    output logic              overflow
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = ADDR_W + 16;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    localparam logic [8:0]     FB_W_L  = 9'(FB_W);
    localparam logic [8:0]     FB_H_L  = 9'(FB_H);
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    logic [ENTRY_W-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;

    logic [0:0]         state_q, state_d;
    logic               mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [15:0]        mem_wdata_q, mem_wdata_d;
    logic               done_pending_q, done_pending_d;
    logic               draw_done_q, draw_done_d;
    logic               overflow_q, overflow_d;

    logic               fifo_empty, fifo_full;
    logic               in_bounds, push, drop, pop, done_fire;
    logic [ADDR_W-1:0]  pix_addr;
    logic [15:0]        pix_rgb;
    logic [ENTRY_W-1:0] head;

    // Address is reduced modulo 2^ADDR_W by evaluating the multiply-add at ADDR_W bits.
    assign pix_addr = ADDR_W'(in_py) * ADDR_W'(FB_W) + ADDR_W'(in_px);
    assign pix_rgb  = {in_color[23:19], in_color[15:10], in_color[7:3]};

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    // Full is judged on pre-edge occupancy, so a simultaneous pop does not make room.
    assign in_bounds = in_valid && ({1'b0, in_px} < FB_W_L) && ({1'b0, in_py} < FB_H_L);
    assign push      = in_bounds && !fifo_full;
    assign drop      = in_bounds && fifo_full;
    assign pop       = !fifo_empty && ((state_q == ST_IDLE) || mem_ack);
    assign head      = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];

    assign done_fire = done_pending_q && fifo_empty && (state_q == ST_IDLE) && !mem_req_q;

    // Next-state logic: FIFO pointers, write FSM, completion and error flags.
    always_comb begin
        wr_ptr_d       = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d       = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        state_d        = state_q;
        mem_req_d      = mem_req_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    mem_addr_d  = head[ENTRY_W-1:16];
                    mem_wdata_d = head[15:0];
                    mem_req_d   = 1'b1;
                    state_d     = ST_REQ;
                end
            end
            default: begin
                if (mem_ack) begin
                    if (!fifo_empty) begin
                        mem_addr_d  = head[ENTRY_W-1:16];
                        mem_wdata_d = head[15:0];
                    end else begin
                        mem_req_d = 1'b0;
                        state_d   = ST_IDLE;
                    end
                end
            end
        endcase

        // A repeated in_done while one is pending folds into the pending one.
        done_pending_d = done_pending_q ? !done_fire : in_done;
        draw_done_d    = done_fire;

        // A drop in the same cycle as clear_err keeps the flag set.
        if (drop)
            overflow_d = 1'b1;
        else if (clear_err)
            overflow_d = 1'b0;
        else
            overflow_d = overflow_q;
    end

    // Control registers; reset abandons any in-flight request and empties the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            state_q        <= ST_IDLE;
            mem_req_q      <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            done_pending_q <= 1'b0;
            draw_done_q    <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            state_q        <= state_d;
            mem_req_q      <= mem_req_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            done_pending_q <= done_pending_d;
            draw_done_q    <= draw_done_d;
            overflow_q     <= overflow_d;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= {pix_addr, pix_rgb};
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign draw_done = draw_done_q;
    assign overflow  = overflow_q;
    assign busy      = !fifo_empty || mem_req_q || done_pending_q;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Scoreboard bench for fb_pixel_writer: stimulus pushes expected writes,
// a negedge monitor pops and compares on every completed handshake.
module tb_fb_pixel_writer;

    localparam int FB_W = 160;
    localparam int FB_H = 120;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_px = '0;
    logic [7:0]  in_py = '0;
    logic [23:0] in_color = '0;
    logic        in_valid = 1'b0;
    logic        in_done = 1'b0;
    logic        clear_err = 1'b0;
    logic        mem_req;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic        busy;
    logic        draw_done;
    logic        overflow;

    fb_pixel_writer #(.FB_W(FB_W), .FB_H(FB_H), .FIFO_DEPTH(16), .ADDR_W(15)) dut (
        .clk(clk), .rst(rst), .in_px(in_px), .in_py(in_py), .in_color(in_color),
        .in_valid(in_valid), .in_done(in_done), .clear_err(clear_err),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .busy(busy), .draw_done(draw_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass = 0;
    int          writes_cnt = 0;
    int          done_cnt = 0;
    bit          jitter_en = 1'b0;
    logic [30:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    endtask

    // Reference model: plain arithmetic from the pixel definition.
    function automatic logic [14:0] ref_addr(input int x, input int y);
        int a;
        a = (y * FB_W + x) % 32768;
        return 15'(a);
    endfunction

    function automatic logic [15:0] ref_rgb(input logic [23:0] c);
        int r, g, b;
        r = int'(c[23:16]); g = int'(c[15:8]); b = int'(c[7:3] * 8);
        return 16'((r / 8) * 2048 + (g / 4) * 32 + b / 8);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
        if (jitter_en) mem_ack = 1'($urandom_range(1, 0));
    endtask

    task automatic send(input int x, input int y, input logic [23:0] c, input bit d, input bit expect_it);
        in_px = 8'(x); in_py = 8'(y); in_color = c; in_valid = 1'b1; in_done = d;
        if (expect_it && x < FB_W && y < FB_H) exp_q.push_back({ref_addr(x, y), ref_rgb(c)});
        cyc();
        in_valid = 1'b0; in_done = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((busy || exp_q.size() != 0) && k < budget) begin
            cyc();
            k++;
        end
        chk("drain_in_time", {31'd0, busy}, 32'd0);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
    endtask

    // Monitor: scoreboard pops on handshake, stall stability, completion ordering.
    bit          prev_stall = 1'b0;
    logic [14:0] prev_addr;
    logic [15:0] prev_data;
    always @(negedge clk) begin
        logic [30:0] e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_req_held", {31'd0, mem_req}, 32'd1);
                chk("stall_addr_stable", {17'd0, mem_addr}, {17'd0, prev_addr});
                chk("stall_data_stable", {16'd0, mem_wdata}, {16'd0, prev_data});
            end
            if (mem_req && mem_ack) begin
                writes_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {17'd0, mem_addr}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", {17'd0, mem_addr}, {17'd0, e[30:16]});
                    chk("wr_data", {16'd0, mem_wdata}, {16'd0, e[15:0]});
                end
            end
            if (draw_done) begin
                done_cnt++;
                chk("done_after_all_writes", exp_q.size() + (mem_req ? 1 : 0), 32'd0);
            end
            prev_stall = mem_req && !mem_ack;
            prev_addr  = mem_addr;
            prev_data  = mem_wdata;
        end
    end

    initial begin
        int w0, d0, n;
        // Reset state.
        cyc(); cyc();
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", {17'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
        chk("rst_draw_done", {31'd0, draw_done}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        cyc();

        // Single pixel with ack tied high, then in_done.
        mem_ack = 1'b1;
        w0 = writes_cnt; d0 = done_cnt;
        send(3, 2, 24'hFF8040, 1'b0, 1'b1);
        chk("latency_req_low_after_push", {31'd0, mem_req}, 32'd0);
        in_done = 1'b1; cyc(); in_done = 1'b0;
        chk("latency_req_high_next", {31'd0, mem_req}, 32'd1);
        repeat (10) cyc();
        chk("single_writes", writes_cnt - w0, 32'd1);
        chk("single_done_pulses", done_cnt - d0, 32'd1);
        chk("single_busy_low", {31'd0, busy}, 32'd0);

        // Clipping.
        w0 = writes_cnt;
        send(160, 0, 24'h123456, 1'b0, 1'b1);
        send(0, 120, 24'h654321, 1'b0, 1'b1);
        send(159, 119, 24'hA5C3E7, 1'b0, 1'b1);
        wait_idle(50);
        chk("clip_writes", writes_cnt - w0, 32'd1);
        chk("clip_no_overflow", {31'd0, overflow}, 32'd0);

        // Stalled memory: 20 pixels, 16 buffered plus one held request survive.
        mem_ack = 1'b0;
        w0 = writes_cnt;
        for (int i = 0; i < 20; i++)
            send($urandom_range(0, FB_W - 1), $urandom_range(0, FB_H - 1),
                 24'($urandom), 1'b0, i < 17);
        chk("stall_overflow_set", {31'd0, overflow}, 32'd1);
        repeat (3) cyc();
        mem_ack = 1'b1;
        wait_idle(100);
        chk("stall_writes", writes_cnt - w0, 32'd17);
        chk("overflow_sticky", {31'd0, overflow}, 32'd1);

        // clear_err, then clear concurrent with a drop.
        clear_err = 1'b1; cyc(); clear_err = 1'b0;
        chk("clear_overflow", {31'd0, overflow}, 32'd0);
        mem_ack = 1'b0;
        w0 = writes_cnt;
        for (int i = 0; i < 17; i++)
            send($urandom_range(0, FB_W - 1), $urandom_range(0, FB_H - 1), 24'($urandom), 1'b0, 1'b1);
        chk("no_drop_yet", {31'd0, overflow}, 32'd0);
        clear_err = 1'b1;
        send(7, 7, 24'h00FF00, 1'b0, 1'b0);
        clear_err = 1'b0;
        chk("drop_beats_clear", {31'd0, overflow}, 32'd1);
        mem_ack = 1'b1;
        wait_idle(100);
        chk("clear_test_writes", writes_cnt - w0, 32'd17);
        clear_err = 1'b1; cyc(); clear_err = 1'b0;

        // Done while 5 pixels queued; a second in_done is absorbed.
        mem_ack = 1'b0;
        d0 = done_cnt;
        for (int i = 0; i < 5; i++)
            send($urandom_range(0, FB_W - 1), $urandom_range(0, FB_H - 1), 24'($urandom), 1'b0, 1'b1);
        in_done = 1'b1; cyc(); in_done = 1'b0;
        cyc();
        in_done = 1'b1; cyc(); in_done = 1'b0;
        repeat (5) cyc();
        chk("no_done_while_queued", done_cnt - d0, 32'd0);
        mem_ack = 1'b1;
        repeat (15) cyc();
        chk("queued_done_once", done_cnt - d0, 32'd1);

        // in_done in the same cycle as the last pixel.
        d0 = done_cnt; w0 = writes_cnt;
        send(10, 20, 24'h102030, 1'b0, 1'b1);
        send(11, 20, 24'h405060, 1'b0, 1'b1);
        send(12, 20, 24'h708090, 1'b1, 1'b1);
        repeat (10) cyc();
        chk("sameedge_writes", writes_cnt - w0, 32'd3);
        chk("sameedge_done_once", done_cnt - d0, 32'd1);

        // Ack jitter with random bursts, some pixels out of bounds.
        jitter_en = 1'b1;
        for (int b = 0; b < 8; b++) begin
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) begin
                send($urandom_range(0, 175), $urandom_range(0, 130), 24'($urandom), 1'b0, 1'b1);
                if ($urandom_range(0, 3) == 0) cyc();
            end
            wait_idle(300);
        end
        jitter_en = 1'b0;
        mem_ack = 1'b1;
        chk("jitter_no_overflow", {31'd0, overflow}, 32'd0);

        // Reset mid-transfer with one request held and 4 queued.
        mem_ack = 1'b0;
        for (int i = 0; i < 5; i++)
            send($urandom_range(0, FB_W - 1), $urandom_range(0, FB_H - 1), 24'($urandom), 1'b0, 1'b1);
        chk("pre_reset_req", {31'd0, mem_req}, 32'd1);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("midrst_mem_addr", {17'd0, mem_addr}, 32'd0);
        chk("midrst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        cyc();
        rst = 1'b0;
        mem_ack = 1'b1;
        w0 = writes_cnt;
        repeat (20) cyc();
        chk("no_writes_after_reset", writes_cnt - w0, 32'd0);
        chk("idle_after_reset", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fb_pixel_writer.md
# fb_pixel_writer

Downstream stage of the shape rasterizer: accepts the rasterizer's registered pixel stream (`px`, `py`, `pixel_color`, `pixel_valid`, `done`) and clips each pixel to the framebuffer bounds. It converts colour from RGB888 to RGB565, buffers the pixels in a small FIFO, and writes them to framebuffer memory over a req/ack handshake. The rasterizer has no backpressure, so this block absorbs bursts and flags any pixel loss. It also reports draw completion only after every accepted pixel has been written.

## Interface
Parameters:
- `FB_W`, 160: framebuffer width in pixels; must be ≤ 256.
- `FB_H`, 120: framebuffer height in pixels; must be ≤ 256.
- `FIFO_DEPTH`, 16: pixel FIFO entries; power of two, ≥ 2.
- `ADDR_W`, 15: memory address width; must satisfy FB_W*FB_H ≤ 2^ADDR_W.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_px`  in  8  pixel x.
- `in_py`  in  8  pixel y.
- `in_color`  in  24  pixel colour, {R[23:16], G[15:8], B[7:0]}.
- `in_valid`  in  1  pixel present this cycle; no backpressure.
- `in_done`  in  1  single-cycle end-of-shape pulse from the rasterizer.
- `clear_err`  in  1  synchronous clear of `overflow`.
- `mem_req`  out  1  write request.
- `mem_addr`  out  ADDR_W  write address, in_py*FB_W + in_px.
- `mem_wdata`  out  16  RGB565 data.
- `mem_ack`  in  1  write accepted; sampled only while `mem_req` = 1.
- `busy`  out  1  FIFO non-empty, `mem_req` high, or a done is pending.
- `draw_done`  out  1  one-cycle pulse when the shape is fully written.
- `overflow`  out  1  sticky: a pixel inside the bounds was dropped because the FIFO was full.

## Operation
- **Accept rule.** When `in_valid` = 1 and `in_px` < FB_W and `in_py` < FB_H, the pixel is in bounds.
  - An in-bounds pixel is pushed as {addr, rgb565} if the FIFO is not full.
  - If the FIFO is full, the in-bounds pixel is dropped and `overflow` is set.
  - Pixels outside the bounds are discarded silently and never set `overflow`.
- **Full flag.** "Full" is evaluated on the pre-edge occupancy. A push coinciding with a pop while the FIFO is full is dropped.
- **Address.** Computed at push time with an unsigned multiply-add, truncated to ADDR_W bits.
- **Colour.** rgb565 = {c[23:19], c[15:10], c[7:3]}.
- **Write FSM, two states: IDLE and REQ.**
  - IDLE: if the FIFO is non-empty, pop the head into `mem_addr`/`mem_wdata`, set `mem_req` = 1, and go to REQ.
  - REQ: `mem_req`, `mem_addr` and `mem_wdata` stay stable until `mem_ack` = 1.
  - On ack with the FIFO non-empty: load the next entry, keep `mem_req` = 1, and stay in REQ (back-to-back writes).
  - On ack with the FIFO empty: set `mem_req` = 0 and go to IDLE.
- **Completion.**
  - `in_done` sets `done_pending`. An `in_valid` pixel arriving in the same cycle as `in_done` belongs to the shape being completed.
  - `draw_done` pulses for one cycle when `done_pending` = 1, the FIFO is empty, and the FSM is in IDLE with `mem_req` = 0. The same edge clears `done_pending`.
  - A second `in_done` while `done_pending` is already set is absorbed and produces one `draw_done` only.
- **Overflow flag.** `clear_err` clears `overflow`. If a clear and a new drop occur in the same cycle, the drop wins and `overflow` remains 1.

## Timing
- **Reset.** Asynchronous. Outputs `mem_req`, `mem_addr`, `mem_wdata`, `draw_done`, `overflow` and `busy` go to 0; the FIFO empties, the FSM enters IDLE, and `done_pending` = 0.
- **Reset mid-transfer.** An in-flight request is abandoned immediately and buffered pixels are lost.
- **Latency.** A pixel accepted at edge N (FIFO write) produces `mem_req` = 1 after edge N+1 when the FSM was idle and the FIFO was empty.
- **Throughput.** One write per cycle while `mem_ack` is held high.
- **Handshake.** A transfer completes on any edge where `mem_req` = 1 and `mem_ack` = 1. `mem_ack` while `mem_req` = 0 is ignored.
- **Pointers.** FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. Full is signalled when the pointers differ only in the MSB.
- **Completion latency.** `draw_done` is asserted at the earliest one cycle after the final write's ack.

## Test plan
- **Single pixel.** Pixel (3,2), colour 0xFF8040, FB_W = 160, `mem_ack` tied to 1 → one write with `mem_addr` = 323 and `mem_wdata` = 0xFC08. `in_done` one cycle later → a single `draw_done` pulse after the write; `busy` then returns to 0.
- **Clipping.** Pixels (160,0), (0,120) and (159,119) → exactly one write, at addr 19199; `overflow` remains 0.
- **Stalled memory.** 20 back-to-back in-bounds pixels with FIFO_DEPTH = 16 and `mem_ack` held at 0 → `overflow` = 1. After ack resumes, exactly 17 writes occur (16 buffered plus the held request), in input order.
- **Ack jitter.** `mem_ack` random at 50%, with the expected data path modelled → `mem_addr` and `mem_wdata` never change while `mem_req` = 1 and no ack; no write is lost or duplicated.
- **Done timing.** `in_done` asserted while 5 pixels are still queued → `draw_done` only after the 5th ack. `in_done` in the same cycle as the last pixel → that pixel is written before `draw_done`.
- **Reset and clear.** Assert `rst` with `mem_req` = 1 and 4 entries queued → all outputs 0 and no further writes. `clear_err` clears `overflow`; a concurrent drop leaves `overflow` at 1.
